uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-write / serial-status bundle between a CPU-side writer and the UART transmitter.
// Latency: none (pure wiring).
// Backpressure: none in-band; the writer watches full/count, a write to a full FIFO is dropped and flagged.
//   uart_in  : [8] write strobe, [7:0] byte
//   tx       : serial line, idle high
//   busy     : FIFO non-empty or frame in flight
//   full     : occupancy == depth
//   overflow : sticky, a write was dropped
//   count    : occupancy 0..depth
interface uart_tx_fifo_if;
  logic [8:0] uart_in;
  logic       tx;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [6:0] count;

  modport master (output uart_in, input tx, busy, full, overflow, count);
  modport slave  (input uart_in, output tx, busy, full, overflow, count);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a circular byte FIFO.
// Latency: byte written at edge N into an empty, idle block drives tx low after edge N+1.
// Backpressure: none; a write seen while full with no pop on the same edge is dropped and sets overflow.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset, clears FIFO, FSM and overflow, tx high
//   bus     : slave side of uart_tx_fifo_if (uart_in in; tx/busy/full/overflow/count out)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int         AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0] DEPTH_C  = 7'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    count_q;
  logic          overflow_q;
  logic          tx_q;
  logic [7:0]    shreg;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;

  logic strobe;
  logic pop;
  logic push;
  logic drop;

  assign strobe = bus.uart_in[8];
  // The FSM takes the head byte on any IDLE edge with data queued.
  assign pop    = (state == IDLE) && (count_q != 7'd0);
  // A pop on the same edge frees a slot, so a full FIFO can still take the write.
  assign push   = strobe && ((count_q != DEPTH_C) || pop);
  assign drop   = strobe && (count_q == DEPTH_C) && !pop;

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  // When full, wr_ptr == rd_ptr; the pop reads the old byte before the write lands.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.uart_in[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Pointers are power-of-two wide, so natural rollover is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {6'd0, push} - {6'd0, pop};
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      shreg   <= '0;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_q    <= 1'b1;
          baud    <= '0;
          bit_idx <= '0;
          if (pop) begin
            shreg <= mem[rd_ptr];
            tx_q  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            tx_q  <= shreg[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              tx_q    <= 1'b1;
              state   <= STOP;
            end else begin
              // Shift so the next bit to send is always shreg[0].
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = (state != IDLE) || (count_q != 7'd0);
  assign bus.full     = (count_q == DEPTH_C);
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_uart_tx_fifo;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared storage for the concurrent writer/receiver scenarios.
  logic [7:0] rxd [20];
  bit         rok [20];
  bit         rto [20];
  int         peak;
  bit         wto;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected line level c cycles into a 40-cycle frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int c);
    int idx;
    idx = c / 4;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  function automatic logic [7:0] wrap_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Mid-bit sampling receiver; started=1 means the current sample is cycle 0 of a start bit.
  task automatic rx_byte(input bit started, output logic [7:0] b, output bit ok, output bit to);
    bit found;
    b     = '0;
    ok    = 1'b1;
    to    = 1'b0;
    found = started;
    for (int n = 0; n < 400 && !found; n++) begin
      step();
      if (u_if.tx === 1'b0) found = 1'b1;
    end
    if (!found) begin
      to = 1'b1;
      ok = 1'b0;
      return;
    end
    step();
    step();
    if (u_if.tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) step();
      b[i] = u_if.tx;
    end
    repeat (4) step();
    if (u_if.tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    u_if.uart_in = '0;
    repeat (3) step();
    total++; if (u_if.tx !== 1'b1)       begin bad++; $display("FAIL reset_tx got %b want 1", u_if.tx); end
    total++; if (u_if.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got %b want 0", u_if.busy); end
    total++; if (u_if.full !== 1'b0)     begin bad++; $display("FAIL reset_full got %b want 0", u_if.full); end
    total++; if (u_if.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", u_if.overflow); end
    total++; if (u_if.count !== 7'd0)    begin bad++; $display("FAIL reset_count got %0d want 0", u_if.count); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    u_if.uart_in = {1'b1, 8'h41};
    step();
    u_if.uart_in = '0;
    total++; if (u_if.count !== 7'd1) begin bad++; $display("FAIL single_count_after_write got %0d want 1", u_if.count); end
    total++; if (u_if.tx !== 1'b1)    begin bad++; $display("FAIL single_tx_before_start got %b want 1", u_if.tx); end
    total++; if (u_if.busy !== 1'b1)  begin bad++; $display("FAIL single_busy got %b want 1", u_if.busy); end
    step();
    for (int c = 0; c < 40; c++) begin
      total++;
      if (u_if.tx !== frame_bit(8'h41, c)) begin
        bad++; $display("FAIL single_wave cycle %0d got %b want %b", c, u_if.tx, frame_bit(8'h41, c));
      end
      step();
    end
    total++; if (u_if.tx !== 1'b1)    begin bad++; $display("FAIL single_idle_tx got %b want 1", u_if.tx); end
    total++; if (u_if.busy !== 1'b0)  begin bad++; $display("FAIL single_idle_busy got %b want 0", u_if.busy); end
    total++; if (u_if.count !== 7'd0) begin bad++; $display("FAIL single_idle_count got %0d want 0", u_if.count); end
  endtask

  task automatic test_back_to_back();
    logic exp;
    u_if.uart_in = {1'b1, 8'h55};
    step();
    u_if.uart_in = {1'b1, 8'hAA};
    step();
    u_if.uart_in = '0;
    for (int c = 0; c < 90; c++) begin
      if (c < 40)       exp = frame_bit(8'h55, c);
      else if (c == 40) exp = 1'b1;
      else if (c < 81)  exp = frame_bit(8'hAA, c - 41);
      else              exp = 1'b1;
      total++;
      if (u_if.tx !== exp) begin
        bad++; $display("FAIL b2b_wave cycle %0d got %b want %b", c, u_if.tx, exp);
      end
      step();
    end
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got %b want 0", u_if.busy); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    bit ok;
    bit to;
    u_if.uart_in = {1'b1, 8'h30};
    step();
    for (int i = 1; i <= 8; i++) begin
      u_if.uart_in = {1'b1, 8'(8'h30 + i)};
      step();
    end
    u_if.uart_in = '0;
    total++; if (u_if.count !== 7'd8) begin bad++; $display("FAIL fp_count_filled got %0d want 8", u_if.count); end
    total++; if (u_if.full !== 1'b1)  begin bad++; $display("FAIL fp_full got %b want 1", u_if.full); end
    repeat (33) step();
    // Now in the first IDLE cycle after the 0x30 frame: the next edge pops.
    total++; if (u_if.tx !== 1'b1) begin bad++; $display("FAIL fp_idle_tx got %b want 1", u_if.tx); end
    u_if.uart_in = {1'b1, 8'h39};
    step();
    u_if.uart_in = '0;
    total++; if (u_if.count !== 7'd8)    begin bad++; $display("FAIL fp_count_pop_write got %0d want 8", u_if.count); end
    total++; if (u_if.overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got %b want 0", u_if.overflow); end
    total++; if (u_if.tx !== 1'b0)       begin bad++; $display("FAIL fp_pop_start got %b want 0", u_if.tx); end
    for (int k = 0; k < 9; k++) begin
      rx_byte(k == 0, b, ok, to);
      total++;
      if (to || !ok || b !== 8'(8'h31 + k)) begin
        bad++; $display("FAIL fp_rx[%0d] got %02h ok=%0d to=%0d want %02h", k, b, ok, to, 8'(8'h31 + k));
      end
    end
    repeat (5) step();
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL fp_busy_end got %b want 0", u_if.busy); end
  endtask

  task automatic test_burst();
    bit saw_low;
    peak = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          u_if.uart_in = {1'b1, 8'(i)};
          step();
          if (int'(u_if.count) > peak) peak = int'(u_if.count);
        end
        u_if.uart_in = '0;
      end
      begin
        for (int k = 0; k < 9; k++) rx_byte(1'b0, rxd[k], rok[k], rto[k]);
      end
    join
    total++; if (peak !== 8)              begin bad++; $display("FAIL burst_peak got %0d want 8", peak); end
    total++; if (u_if.overflow !== 1'b1)  begin bad++; $display("FAIL burst_overflow got %b want 1", u_if.overflow); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (rto[k] || !rok[k] || rxd[k] !== 8'(k)) begin
        bad++; $display("FAIL burst_rx[%0d] got %02h ok=%0d to=%0d want %02h", k, rxd[k], rok[k], rto[k], 8'(k));
      end
    end
    saw_low = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (u_if.tx === 1'b0) saw_low = 1'b1;
    end
    total++; if (saw_low !== 1'b0)   begin bad++; $display("FAIL burst_extra_frame got %b want 0", saw_low); end
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL burst_busy_end got %b want 0", u_if.busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    bit ok;
    bit to;
    u_if.uart_in = {1'b1, 8'hC3};
    step();
    u_if.uart_in = {1'b1, 8'h11};
    step();
    u_if.uart_in = {1'b1, 8'h22};
    step();
    u_if.uart_in = '0;
    repeat (15) step();
    // Data bit 3 of 0xC3 is on the line (0).
    total++; if (u_if.tx !== 1'b0)       begin bad++; $display("FAIL rm_bit3 got %b want 0", u_if.tx); end
    total++; if (u_if.overflow !== 1'b1) begin bad++; $display("FAIL rm_pre_overflow got %b want 1", u_if.overflow); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (u_if.tx !== 1'b1)       begin bad++; $display("FAIL rm_tx got %b want 1", u_if.tx); end
    total++; if (u_if.count !== 7'd0)    begin bad++; $display("FAIL rm_count got %0d want 0", u_if.count); end
    total++; if (u_if.overflow !== 1'b0) begin bad++; $display("FAIL rm_overflow got %b want 0", u_if.overflow); end
    total++; if (u_if.busy !== 1'b0)     begin bad++; $display("FAIL rm_busy got %b want 0", u_if.busy); end
    step();
    step();
    reset_n      = 1'b1;
    u_if.uart_in = {1'b1, 8'h0F};
    step();
    u_if.uart_in = '0;
    total++; if (u_if.count !== 7'd1) begin bad++; $display("FAIL rm_first_write got %0d want 1", u_if.count); end
    rx_byte(1'b0, b, ok, to);
    total++;
    if (to || !ok || b !== 8'h0F) begin
      bad++; $display("FAIL rm_rx got %02h ok=%0d to=%0d want 0f", b, ok, to);
    end
    repeat (5) step();
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL rm_busy_end got %b want 0", u_if.busy); end
  endtask

  task automatic test_wrap();
    wto = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          for (int w = 0; w < 2000 && u_if.full === 1'b1; w++) step();
          if (u_if.full === 1'b1) wto = 1'b1;
          u_if.uart_in = {1'b1, wrap_byte(i)};
          step();
          u_if.uart_in = '0;
        end
      end
      begin
        for (int k = 0; k < 20; k++) rx_byte(1'b0, rxd[k], rok[k], rto[k]);
      end
    join
    total++; if (wto !== 1'b0)           begin bad++; $display("FAIL wrap_full_wait got %b want 0", wto); end
    total++; if (u_if.overflow !== 1'b0) begin bad++; $display("FAIL wrap_overflow got %b want 0", u_if.overflow); end
    for (int k = 0; k < 20; k++) begin
      total++;
      if (rto[k] || !rok[k] || rxd[k] !== wrap_byte(k)) begin
        bad++; $display("FAIL wrap_rx[%0d] got %02h ok=%0d to=%0d want %02h", k, rxd[k], rok[k], rto[k], wrap_byte(k));
      end
    end
    repeat (5) step();
    total++; if (u_if.count !== 7'd0) begin bad++; $display("FAIL wrap_count_end got %0d want 0", u_if.count); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    u_if.uart_in = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_burst();
    test_reset_mid_frame();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
